// File: rtl/ysyx_22050368_fetch_ctrl_if.sv
// Fetch controller bus bundle: redirect/hold from execute, imem request/response, decode output.
interface ysyx_22050368_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_flag_i;
  logic              req_valid_o;
  logic [ADDR_W-1:0] req_addr_o;
  logic              req_ready_i;
  logic              rsp_valid_i;
  logic [INST_W-1:0] rsp_inst_i;
  logic              inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;

  // Fetch controller side
  modport master (
    input  jump_flag_i, jump_addr_i, hold_flag_i, req_ready_i, rsp_valid_i, rsp_inst_i,
    output req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_pc_o
  );

  // Environment side (imem + execute/decode)
  modport slave (
    output jump_flag_i, jump_addr_i, hold_flag_i, req_ready_i, rsp_valid_i, rsp_inst_i,
    input  req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_pc_o
  );
endinterface

// File: rtl/ysyx_22050368_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, keeps one imem request outstanding and hands
// instructions to decode through a registered output stage backed by a one-entry skid.
module ysyx_22050368_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22050368_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] fly_pc_q;
  logic              kill_q;
  logic              out_valid_q;
  logic [INST_W-1:0] out_inst_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic              skid_valid_q;
  logic [INST_W-1:0] skid_inst_q;
  logic [ADDR_W-1:0] skid_pc_q;

  logic              consume;
  logic [ADDR_W-1:0] jump_pc;
  logic              unused_jump_lsb;

  assign consume         = out_valid_q & ~bus.hold_flag_i;
  assign jump_pc         = {bus.jump_addr_i[ADDR_W-1:2], 2'b00};
  assign unused_jump_lsb = ^bus.jump_addr_i[1:0];

  assign bus.req_valid_o  = (state_q == StReq);
  assign bus.req_addr_o   = pc_q;
  assign bus.inst_valid_o = out_valid_q;
  assign bus.inst_o       = out_inst_q;
  assign bus.inst_pc_o    = out_pc_q;

  // Fetch sequencing: reset, then redirect (overrides everything), then normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      fly_pc_q     <= '0;
      kill_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
    end else if (bus.jump_flag_i) begin
      pc_q         <= jump_pc;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      unique case (state_q)
        StWait: begin
          if (bus.rsp_valid_i) begin
            // Stale response lands this cycle; drop it and refetch at once.
            kill_q  <= 1'b0;
            state_q <= StReq;
          end else begin
            kill_q  <= 1'b1;
          end
        end
        StReq: begin
          // A request accepted together with the jump is old-path and still in flight.
          if (bus.req_ready_i) begin
            fly_pc_q <= pc_q;
            kill_q   <= 1'b1;
            state_q  <= StWait;
          end
        end
        default: begin
          kill_q  <= 1'b0;
          state_q <= StReq;
        end
      endcase
    end else begin
      if (consume) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (bus.req_ready_i) begin
            fly_pc_q <= pc_q;
            pc_q     <= pc_q + ADDR_W'(4);
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (bus.rsp_valid_i) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= StReq;
            end else if (!out_valid_q || consume) begin
              out_valid_q <= 1'b1;
              out_inst_q  <= bus.rsp_inst_i;
              out_pc_q    <= fly_pc_q;
              state_q     <= StReq;
            end else begin
              skid_valid_q <= 1'b1;
              skid_inst_q  <= bus.rsp_inst_i;
              skid_pc_q    <= fly_pc_q;
              state_q      <= StFull;
            end
          end
        end
        StFull: begin
          if (consume) begin
            out_valid_q  <= 1'b1;
            out_inst_q   <= skid_inst_q;
            out_pc_q     <= skid_pc_q;
            skid_valid_q <= 1'b0;
            state_q      <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
